ula_mdu_ctrl: RTL and testbench
===============================

# ula_mdu_ctrl

Next-generation ULA control unit. It keeps the combinational AluOp/func → ULA op decode and adds a parametrised, iterative multiply/divide unit (MDU) for MULT/MULTU/DIV/DIVU, with architectural HI/LO registers and MFHI/MFLO/MTHI/MTLO support. It sits in the execute stage beside the ULA and raises `stall` to freeze the pipeline while a multi-cycle operation runs.

## Interface
- `WIDTH`, default 32: operand, HI and LO width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `AluOp`  in  3  main-control ALU class.
- `func`  in  6  R-type function field.
- `valid`  in  1  instruction present in the execute stage this cycle.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `op`  out  4  ULA operation code, combinational.
- `stall`  out  1  holds the pipeline while the MDU is busy.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `mdu_rd`  out  WIDTH  MFHI → `hi`, MFLO → `lo`, else 0 (combinational).
- `mdu_rd_sel`  out  1  high for a valid MFHI/MFLO; selects `mdu_rd` onto the writeback path.

## Operation
- `op` decode:
  - AluOp 000 → 0010; 001 → 0110; 010 → 0000; 011 → 0001; 100 → 1101; 101 → 0111; 111 → 0000.
  - AluOp 110 by `func`: 000100 → 1110; 000110 → 1111; 000111 → 1010; 000011 → 0100; 000010 → 0101; 000000 → 0011; 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 100110 → 1101; 100111 → 1100; 101010/101011 → 0111.
  - Any other `func` (including MDU functions) → 0000.
- MDU functions (AluOp 110 only): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- States:
  - IDLE: a valid MULT/MULTU/DIV/DIVU starts the operation. At the clock edge the block latches the operand magnitudes (absolute values for signed ops), sign flags and kind, clears the count, and moves to RUN.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, for `WIDTH` cycles, then FIX.
  - FIX: applies sign correction and writes HI/LO at the edge, then DONE.
  - DONE: `stall`=0 so the stalled instruction retires. Starts are ignored. Always returns to IDLE.
- `stall` = (state ∈ {RUN, FIX}) OR (IDLE AND valid start).
- Multiply: 2·WIDTH-bit product; HI = upper half, LO = lower half. Signed: negate the product when operand signs differ.
- Divide: LO = quotient, HI = remainder. Signed: quotient negative iff signs differ; remainder takes the dividend's sign. MIN/−1 → LO = MIN, HI = 0 (two's-complement wrap).
- Divide by zero (either signedness): HI = `a`, LO = all ones. Sign fix is skipped.
- MTHI/MTLO: write `a` at the edge when valid in IDLE. They are not accepted in other states; the pipeline cannot present them there.

## Timing
- Reset (asynchronous, any state including mid-RUN): state = IDLE, count = 0, `hi` = `lo` = 0, `stall` = 0. Any in-flight result is discarded.
- MDU latency: issue cycle + `WIDTH` RUN + 1 FIX = `WIDTH`+2 stall cycles. The instruction retires in DONE. HI/LO are visible from the DONE cycle onward.
- Back-to-back MDU ops: the next instruction arrives in IDLE after DONE and starts normally. Minimum spacing is `WIDTH`+3 cycles.
- MFHI/MFLO in the cycle immediately after a DONE or MTxx returns the new value.
- `op`, `mdu_rd` and `mdu_rd_sel` are purely combinational. They are not affected by state, except that `mdu_rd_sel` requires `valid`.

## Structure
- Shared package `ula_pkg`:
  - op-code constants (4-bit);
  - AluOp constants;
  - func constants (shift, arithmetic, MDU);
  - MDU state encoding (IDLE, RUN, FIX, DONE).
- Sub-module `mdu_iter`: iterative datapath (accumulator/remainder, shift register, counter), parametrised by `WIDTH`, with start/kind inputs and a done output. The top level holds the decode, the FSM, HI/LO and the sign handling.

## Test plan
- AluOp 110/func 100111 → `op` 1100; AluOp 001 → 0110; AluOp 111 → 0000; `stall` stays 0.
- MULT a=0xFFFFFFFD, b=7 → `stall` high 34 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; following MFLO → `mdu_rd`=0xFFFFFFEB, `mdu_rd_sel`=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU a=5, b=0 → `hi`=5, `lo`=0xFFFFFFFF after 34 stall cycles.
- MULTU issued, `rst_n` pulsed low at RUN count 10 → `stall`, `hi`, `lo` = 0 immediately. Reissue MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- MTHI a=0x1234 then MFHI next cycle → `mdu_rd`=0x1234. MULT held valid through DONE → exactly one operation executes.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the ULA control unit and its multiply/divide unit.
//   - 4-bit ULA operation codes driven on `op`
//   - 3-bit AluOp classes from main control
//   - 6-bit R-type function codes (shift, arithmetic, MDU)
//   - MDU state encoding
package ula_pkg;

    // ULA operation codes
    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSll  = 4'b0011;
    localparam logic [3:0] OpSra  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSrav = 4'b1010;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpXor  = 4'b1101;
    localparam logic [3:0] OpSllv = 4'b1110;
    localparam logic [3:0] OpSrlv = 4'b1111;

    // AluOp classes
    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluXor   = 3'b100;
    localparam logic [2:0] AluSlt   = 3'b101;
    localparam logic [2:0] AluRtype = 3'b110;
    localparam logic [2:0] AluNone  = 3'b111;

    // Shift function codes
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnSrlv = 6'b000110;
    localparam logic [5:0] FnSrav = 6'b000111;
    // Arithmetic / logic function codes
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSltu = 6'b101011;
    // MDU function codes
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    typedef enum logic [1:0] {
        MduIdle = 2'b00,
        MduRun  = 2'b01,
        MduFix  = 2'b10,
        MduDone = 2'b11
    } mdu_state_e;

    // True for the four multi-cycle MDU arithmetic functions.
    function automatic logic is_mdu_arith(input logic [5:0] f);
        return (f == FnMult) || (f == FnMultu) || (f == FnDiv) || (f == FnDivu);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned multiply/divide datapath, one step per cycle.
//   clk, rst_n     clock, async active-low reset
//   start          load operands (op_a, op_b) and clear the step counter
//   step           perform one shift-add / restoring-subtract step
//   is_div         operation kind sampled on start (1 = divide)
//   op_a, op_b     unsigned magnitudes: multiplicand/multiplier or dividend/divisor
//   last           the current step is the final one
//   acc            multiply: product upper half; divide: remainder
//   low            multiply: product lower half; divide: quotient
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] low
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, opnd_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             div_q;
    logic [WIDTH:0]   sum, shifted, diff;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
        shifted = {acc_q, low_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        acc_d   = acc_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        if (start) begin
            acc_d = '0;
            low_d = is_div ? op_a : op_b;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                // Restoring division: quotient bits enter low, dividend bits leave it.
                if (shifted >= {1'b0, opnd_q}) begin
                    acc_d = diff[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Shift-add: {acc, low} shifts right, multiplier bits consumed from low[0].
                acc_d = sum[WIDTH:1];
                low_d = {sum[0], low_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            low_q  <= '0;
            cnt_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            low_q <= low_d;
            cnt_q <= cnt_d;
            if (start) begin
                opnd_q <= is_div ? op_b : op_a;
                div_q  <= is_div;
            end
        end
    end

    assign last = (cnt_q == CntW'(WIDTH - 1));
    assign acc  = acc_q;
    assign low  = low_q;

endmodule

// File: rtl/ula_mdu_ctrl.sv
// ula_mdu_ctrl: ULA operation decode plus multi-cycle multiply/divide control with HI/LO.
//   clk, rst_n        clock, async active-low reset
//   AluOp, func       main-control ALU class and R-type function field
//   valid             instruction present in execute this cycle
//   a, b              rs / rt operands
//   op                ULA operation code (combinational)
//   stall             pipeline hold while an MDU operation runs
//   hi, lo            architectural HI/LO registers
//   mdu_rd, mdu_rd_sel  MFHI/MFLO read data and writeback select
module ula_mdu_ctrl
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       AluOp,
    input  logic [5:0]       func,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       op,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdu_rd,
    output logic             mdu_rd_sel
);
    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, sgn_a_q, divz_q, div_q;
    logic             is_r, start, is_div, is_signed, sign_a, sign_b, last;
    logic [WIDTH-1:0] mag_a, mag_b, acc, low, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // ULA decode
    always_comb begin
        op = OpAnd;
        case (AluOp)
            AluAdd:   op = OpAdd;
            AluSub:   op = OpSub;
            AluAnd:   op = OpAnd;
            AluOr:    op = OpOr;
            AluXor:   op = OpXor;
            AluSlt:   op = OpSlt;
            AluRtype: begin
                case (func)
                    FnSllv:         op = OpSllv;
                    FnSrlv:         op = OpSrlv;
                    FnSrav:         op = OpSrav;
                    FnSra:          op = OpSra;
                    FnSrl:          op = OpSrl;
                    FnSll:          op = OpSll;
                    FnAdd:          op = OpAdd;
                    FnSub:          op = OpSub;
                    FnAnd:          op = OpAnd;
                    FnOr:           op = OpOr;
                    FnXor:          op = OpXor;
                    FnNor:          op = OpNor;
                    FnSlt, FnSltu:  op = OpSlt;
                    default:        op = OpAnd;
                endcase
            end
            default:  op = OpAnd;
        endcase
    end

    assign is_r       = (AluOp == AluRtype);
    assign mdu_rd_sel = valid && is_r && ((func == FnMfhi) || (func == FnMflo));
    assign mdu_rd     = (is_r && func == FnMfhi) ? hi_q :
                        (is_r && func == FnMflo) ? lo_q : '0;

    // Operand conditioning for a start
    assign start     = (state_q == MduIdle) && valid && is_r && is_mdu_arith(func);
    assign is_div    = func[1];
    assign is_signed = ~func[0];
    assign sign_a    = is_signed & a[WIDTH-1];
    assign sign_b    = is_signed & b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (state_q == MduRun),
        .is_div (is_div),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .last   (last),
        .acc    (acc),
        .low    (low)
    );

    // FSM next state and stall
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            MduIdle: begin
                if (start) begin
                    state_d = MduRun;
                    stall   = 1'b1;
                end
            end
            MduRun: begin
                stall = 1'b1;
                if (last) state_d = MduFix;
            end
            MduFix: begin
                stall   = 1'b1;
                state_d = MduDone;
            end
            default: state_d = MduIdle;
        endcase
    end

    // Sign correction; remainder follows the dividend, which also yields HI = a on divide by 0.
    assign prod_fix = neg_q ? -{acc, low} : {acc, low};
    assign rem_fix  = sgn_a_q ? -acc : acc;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            MduIdle: begin
                if (valid && is_r && func == FnMthi) hi_d = a;
                if (valid && is_r && func == FnMtlo) lo_d = a;
            end
            MduFix: begin
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (divz_q) begin
                    hi_d = rem_fix;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = neg_q ? -low : low;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MduIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            divz_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start) begin
                neg_q   <= sign_a ^ sign_b;
                sgn_a_q <= sign_a;
                divz_q  <= (b == '0);
                div_q   <= is_div;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_ula_mdu_ctrl.sv
// Self-checking bench for ula_mdu_ctrl: decode table, directed MDU sequences and random MDU ops
// against an arithmetic reference model.
module tb_ula_mdu_ctrl;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   AluOp = 3'b000;
    logic [5:0]   func = 6'b000000;
    logic         valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op;
    logic         stall;
    logic [W-1:0] hi, lo, mdu_rd;
    logic         mdu_rd_sel;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ula_mdu_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AluOp      (AluOp),
        .func       (func),
        .valid      (valid),
        .a          (a),
        .b          (b),
        .op         (op),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo),
        .mdu_rd     (mdu_rd),
        .mdu_rd_sel (mdu_rd_sel)
    );

    typedef struct packed {
        logic [2:0] aluop;
        logic [5:0] fn;
        logic [3:0] exp_op;
    } dec_vec_t;

    dec_vec_t vecs[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, p;
        int ix, iy;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = int'(x);
        iy = int'(y);
        case (f)
            6'b011000: begin p = sx * sy; return p; end
            6'b011001: begin up = {32'b0, x} * {32'b0, y}; return up; end
            6'b011010: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one MDU op, hold valid until it retires, then MFLO in the following cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input string name);
        logic [63:0] exp;
        int cyc;
        exp = model(f, x, y);
        @(posedge clk); #1;
        valid = 1'b1; AluOp = 3'b110; func = f; a = x; b = y;
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(posedge clk); #2;
        end
        check({name, " stall cycles"}, 64'(cyc), 64'(W + 2));
        check({name, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({name, " lo"}, 64'(lo), 64'(exp[31:0]));
        @(posedge clk); #1;
        func = 6'b010010; a = '0; b = '0;
        #1;
        check({name, " no restart"}, 64'(stall), 64'(0));
        check({name, " mflo rd"}, 64'(mdu_rd), 64'(exp[31:0]));
        check({name, " mflo sel"}, 64'(mdu_rd_sel), 64'(1));
        valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset stall", 64'(stall), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        #20 rst_n = 1'b1;

        // Decode table (valid low so nothing starts)
        vecs[0]  = '{3'b000, 6'b100111, 4'b0010};
        vecs[1]  = '{3'b001, 6'b100111, 4'b0110};
        vecs[2]  = '{3'b010, 6'b000000, 4'b0000};
        vecs[3]  = '{3'b011, 6'b000000, 4'b0001};
        vecs[4]  = '{3'b100, 6'b000000, 4'b1101};
        vecs[5]  = '{3'b101, 6'b000000, 4'b0111};
        vecs[6]  = '{3'b111, 6'b100000, 4'b0000};
        vecs[7]  = '{3'b110, 6'b000100, 4'b1110};
        vecs[8]  = '{3'b110, 6'b000110, 4'b1111};
        vecs[9]  = '{3'b110, 6'b000111, 4'b1010};
        vecs[10] = '{3'b110, 6'b000011, 4'b0100};
        vecs[11] = '{3'b110, 6'b000010, 4'b0101};
        vecs[12] = '{3'b110, 6'b000000, 4'b0011};
        vecs[13] = '{3'b110, 6'b100000, 4'b0010};
        vecs[14] = '{3'b110, 6'b100010, 4'b0110};
        vecs[15] = '{3'b110, 6'b100100, 4'b0000};
        vecs[16] = '{3'b110, 6'b100101, 4'b0001};
        vecs[17] = '{3'b110, 6'b100110, 4'b1101};
        vecs[18] = '{3'b110, 6'b100111, 4'b1100};
        vecs[19] = '{3'b110, 6'b101010, 4'b0111};
        vecs[20] = '{3'b110, 6'b101011, 4'b0111};
        vecs[21] = '{3'b110, 6'b011000, 4'b0000};
        vecs[22] = '{3'b110, 6'b010000, 4'b0000};
        vecs[23] = '{3'b110, 6'b111111, 4'b0000};
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            valid = 1'b0; AluOp = vecs[i].aluop; func = vecs[i].fn;
            #1;
            check($sformatf("decode[%0d] op", i), 64'(op), 64'(vecs[i].exp_op));
            check($sformatf("decode[%0d] stall", i), 64'(stall), 64'(0));
            check($sformatf("decode[%0d] sel", i), 64'(mdu_rd_sel), 64'(0));
        end

        // Directed MDU sequences
        run_op(6'b011000, 32'hFFFF_FFFD, 32'd7, "mult neg");
        run_op(6'b011010, 32'hFFFF_FFF9, 32'd2, "div neg");
        run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        run_op(6'b011011, 32'd5, 32'd0, "divu by 0");
        run_op(6'b011010, 32'hFFFF_FFF9, 32'd0, "div neg by 0");

        // Reset in the middle of RUN
        @(posedge clk); #1;
        valid = 1'b1; AluOp = 3'b110; func = 6'b011001; a = 32'hFFFF_FFFF; b = 32'd2;
        repeat (11) @(posedge clk);
        #1;
        check("pre-reset stall", 64'(stall), 64'(1));
        valid = 1'b0; rst_n = 1'b0;
        #1;
        check("mid-run reset stall", 64'(stall), 64'(0));
        check("mid-run reset hi", 64'(hi), 64'(0));
        check("mid-run reset lo", 64'(lo), 64'(0));
        #3 rst_n = 1'b1;
        run_op(6'b011001, 32'hFFFF_FFFF, 32'd2, "multu reissue");

        // MTHI/MTLO then read back next cycle
        @(posedge clk); #1;
        valid = 1'b1; AluOp = 3'b110; func = 6'b010001; a = 32'h1234;
        @(posedge clk); #1;
        func = 6'b010011; a = 32'hABCD;
        #1;
        check("mthi stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        func = 6'b010000; a = '0;
        #1;
        check("mfhi rd", 64'(mdu_rd), 64'h1234);
        check("mfhi sel", 64'(mdu_rd_sel), 64'(1));
        func = 6'b010010;
        #1;
        check("mflo rd", 64'(mdu_rd), 64'hABCD);
        valid = 1'b0;
        #1;
        check("mflo sel no valid", 64'(mdu_rd_sel), 64'(0));

        // Random MDU ops against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [5:0] f;
            logic [31:0] x, y;
            f = 6'b011000 | 6'($urandom_range(0, 3));
            x = $urandom;
            y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom);
            run_op(f, x, y, $sformatf("rand[%0d] f=%0h a=%0h b=%0h", i, f, x, y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
